// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared defaults, FSM state encoding and helpers for mem_arbiter
package mem_arb_pkg;
    localparam int NUM_REQ_DEF = 4;
    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        ARB = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: combinational round-robin pick of the first requester at or after rr_ptr
//   req    : per-requester request vector
//   rr_ptr : index with highest priority this cycle
//   gnt    : one-hot grant, zero when req is zero
module mem_arb_rr_pick import mem_arb_pkg::*; #(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int PTR_W = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt
);
    logic [NUM_REQ-1:0] hi;
    logic [NUM_REQ-1:0] sel;

    // Requests at or above the pointer win first; otherwise wrap to the lowest index.
    // x & -x isolates the lowest set bit.
    always_comb begin
        hi = req & ({NUM_REQ{1'b1}} << rr_ptr);
        sel = (|hi) ? hi : req;
        gnt = sel & (~sel + NUM_REQ'(1));
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one registered memory port among NUM_REQ requesters
//   clk, reset                  : clock, synchronous active-high reset
//   req, we, lock               : per-requester request, write select, bus-retention request
//   addr, wdata                 : packed per-requester address / write data (slice k = requester k)
//   gnt                         : combinational one-hot grant (handshake = req & gnt)
//   rvalid, rdata               : per-requester read-return strobe, shared read data
//   m_adrs, m_wdata, m_w_en, m_r_en : registered memory command
//   m_rdata, m_r_valid          : memory read return (two cycles after the handshake)
// Build option: define MEM_ARB_LOCK_EN to enable lock/LOCK-state bus retention.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         m_adrs,
    output logic [DATA_W-1:0]         m_wdata,
    output logic                      m_w_en,
    output logic                      m_r_en,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_r_valid
);
    localparam int PTR_W = ptr_w(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win;
    logic [NUM_REQ-1:0] req_eff;
    logic [NUM_REQ-1:0] pick;
    logic               hs;
    logic               win_we;
    logic [ADDR_W-1:0]  win_adrs;
    logic [DATA_W-1:0]  win_wdata;
    logic               id1_v;
    logic               id2_v;
    logic [PTR_W-1:0]   id1;
    logic [PTR_W-1:0]   id2;

`ifdef MEM_ARB_LOCK_EN
    arb_state_t       state;
    arb_state_t       state_nx;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] owner_nx;
    logic             win_lock;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB;
            owner <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
        end
    end

    // Any handshake re-decides retention from the winner's lock bit; in LOCK only
    // the owner can win, so its lock=0 handshake is what returns to ARB.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        win_lock = |(gnt & lock);
        if (hs) begin
            state_nx = win_lock ? LOCK : ARB;
            owner_nx = win_lock ? win : owner;
        end
    end

    assign req_eff = (state == LOCK) ? (req & (NUM_REQ'(1) << owner)) : req;
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign req_eff = req;
`endif

    mem_arb_rr_pick #(
        .NUM_REQ(NUM_REQ),
        .PTR_W(PTR_W)
    ) u_pick (
        .req(req_eff),
        .rr_ptr(rr_ptr),
        .gnt(pick)
    );

    assign gnt = reset ? '0 : pick;

    always_comb begin
        hs = |gnt;
        win = '0;
        win_we = 1'b0;
        win_adrs = '0;
        win_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                win = PTR_W'(k);
                win_we = we[k];
                win_adrs = addr[k*ADDR_W +: ADDR_W];
                win_wdata = wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // id1/id2 track which requester owns the read returning two cycles later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            m_w_en <= 1'b0;
            m_r_en <= 1'b0;
            m_adrs <= '0;
            m_wdata <= '0;
            id1_v <= 1'b0;
            id2_v <= 1'b0;
            id1 <= '0;
            id2 <= '0;
        end else begin
            m_w_en <= hs & win_we;
            m_r_en <= hs & ~win_we;
            id1_v <= hs & ~win_we;
            id1 <= win;
            id2_v <= id1_v;
            id2 <= id1;
            if (hs) begin
                rr_ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
                m_adrs <= win_adrs;
                m_wdata <= win_wdata;
            end
        end
    end

    assign rvalid = (!reset && id2_v && m_r_valid) ? (NUM_REQ'(1) << id2) : '0;
    assign rdata = m_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;
    localparam int N = 4;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] we = '0;
    logic [N-1:0] lock = '0;
    logic [AW-1:0] r_addr [N];
    logic [DW-1:0] r_wdata [N];
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0] gnt;
    logic [N-1:0] rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] m_adrs;
    logic [DW-1:0] m_wdata;
    logic m_w_en;
    logic m_r_en;
    logic [DW-1:0] m_rdata;
    logic m_r_valid;

    logic [DW-1:0] mem [0:2**AW-1];
    logic [DW-1:0] mem_rd = '0;
    logic mem_rv = 1'b0;
    logic spur = 1'b0;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [DW-1:0] ref_mem [0:2**AW-1];
    int m_ptr = 0;
    int m_owner = 0;
    int m_last = -1;
    int cyc = 0;
    bit m_locked = 1'b0;
    bit e_wen = 1'b0;
    bit e_ren = 1'b0;
    logic [AW-1:0] e_adrs = '0;
    logic [DW-1:0] e_wdata = '0;
    bit s_v [4];
    int s_id [4];
    logic [DW-1:0] s_data [4];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign addr[g*AW +: AW] = r_addr[g];
        assign wdata[g*DW +: DW] = r_wdata[g];
    end

    mem_arbiter dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .we(we),
        .lock(lock),
        .addr(addr),
        .wdata(wdata),
        .gnt(gnt),
        .rvalid(rvalid),
        .rdata(rdata),
        .m_adrs(m_adrs),
        .m_wdata(m_wdata),
        .m_w_en(m_w_en),
        .m_r_en(m_r_en),
        .m_rdata(m_rdata),
        .m_r_valid(m_r_valid)
    );

    always #5 clk = ~clk;

    // memory with one-cycle registered read; spur injects stray read-valids
    always @(posedge clk) begin
        mem_rv <= m_r_en;
        if (m_r_en) mem_rd <= mem[m_adrs];
        if (m_w_en) mem[m_adrs] <= m_wdata;
    end
    assign m_r_valid = mem_rv | spur;
    assign m_rdata = mem_rd;

    function automatic int model_win();
        int k;
        logic [PW-1:0] ks;
        if (reset) return -1;
        for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            ks = k[PW-1:0];
            if (req[ks] && (!m_locked || k == m_owner)) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_gnt();
        int w;
        w = model_win();
        return (w < 0) ? '0 : (N'(1) << w);
    endfunction

    function automatic logic [N-1:0] exp_rv();
        logic [1:0] s;
        s = cyc[1:0];
        return (!reset && s_v[s]) ? (N'(1) << s_id[s]) : '0;
    endfunction

    function automatic logic [DW-1:0] exp_rd();
        logic [1:0] s;
        s = cyc[1:0];
        return s_data[s];
    endfunction

    // Model: each handshake schedules its command for the next cycle and, for a read,
    // a return two cycles after the handshake carrying the data of all earlier writes.
    always @(posedge clk) begin : model
        int w;
        logic [PW-1:0] wi;
        logic [1:0] due;
        w = model_win();
        s_v[cyc[1:0]] = 1'b0;
        if (reset) begin
            m_ptr = 0;
            m_owner = 0;
            m_locked = 1'b0;
            m_last = -1;
            e_wen = 1'b0;
            e_ren = 1'b0;
            e_adrs = '0;
            e_wdata = '0;
            s_v = '{default: 1'b0};
        end else begin
            m_last = w;
            e_wen = 1'b0;
            e_ren = 1'b0;
            if (w >= 0) begin
                wi = w[PW-1:0];
                m_ptr = (w + 1) % N;
                e_adrs = r_addr[wi];
                e_wdata = r_wdata[wi];
                if (we[wi]) begin
                    e_wen = 1'b1;
                    ref_mem[r_addr[wi]] = r_wdata[wi];
                end else begin
                    e_ren = 1'b1;
                    due = cyc[1:0] + 2'd2;
                    s_v[due] = 1'b1;
                    s_id[due] = w;
                    s_data[due] = ref_mem[r_addr[wi]];
                end
`ifdef MEM_ARB_LOCK_EN
                m_locked = lock[wi];
                if (m_locked) m_owner = w;
`endif
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        req = '0;
        lock = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        reset = 1'b1;
        req = 4'b1111;
        we = 4'b0101;
        tick();
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++;
        if (rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid: got %b expected 0000", rvalid); end
        checks++;
        if ({m_w_en, m_r_en} !== 2'b00) begin errors++; $display("FAIL reset_en: got %b%b expected 00", m_w_en, m_r_en); end
        checks++;
        if (m_adrs !== '0 || m_wdata !== '0) begin errors++; $display("FAIL reset_cmd: got adrs %h wdata %h expected 0", m_adrs, m_wdata); end
        tick();
        reset = 1'b0;
        req = '0;
        we = '0;
    endtask

    task automatic test_rr_sequence();
        logic [N-1:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int k = 0; k < N; k++) r_addr[k[PW-1:0]] = AW'($urandom_range(0, 2**AW - 1));
        for (int i = 0; i < 7; i++) begin
            tick();
            req = (i < 5) ? 4'b1111 : 4'b0000;
            we = '0;
            @(negedge clk);
            if (i < 5) begin
                checks++;
                if (gnt !== seq[i[2:0]]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt, seq[i[2:0]]); end
            end
            checks++;
            if (i >= 2 && rvalid !== seq[3'(i - 2)]) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, rvalid, seq[3'(i - 2)]); end
            else if (i < 2 && rvalid !== 4'b0000) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b expected 0000", i, rvalid); end
            if (i >= 2) begin
                checks++;
                if (rdata !== exp_rd()) begin errors++; $display("FAIL rr_rdata[%0d]: got %h expected %h", i, rdata, exp_rd()); end
            end
        end
    endtask

    task automatic test_write_read();
        do_reset();
        tick();
        req = 4'b0010;
        we = 4'b0010;
        r_addr[1] = 11'h005;
        r_wdata[1] = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL wr_gnt: got %b expected 0010", gnt); end
        tick();
        req = 4'b0100;
        we = 4'b0000;
        r_addr[2] = 11'h005;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("FAIL rd_gnt: got %b expected 0100", gnt); end
        checks++;
        if (m_w_en !== 1'b1 || m_adrs !== 11'h005 || m_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_cmd: got w_en %b adrs %h wdata %h expected 1 005 deadbeef", m_w_en, m_adrs, m_wdata);
        end
        tick();
        req = '0;
        @(negedge clk);
        checks++;
        if (m_r_en !== 1'b1 || m_w_en !== 1'b0 || m_adrs !== 11'h005) begin
            errors++; $display("FAIL rd_cmd: got r_en %b w_en %b adrs %h expected 1 0 005", m_r_en, m_w_en, m_adrs);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rvalid !== 4'b0100 || rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_rd_return: got rvalid %b rdata %h expected 0100 deadbeef", rvalid, rdata);
        end
    endtask

    task automatic test_lock();
        logic [N-1:0] rq [5];
        logic [N-1:0] lk [5];
        logic [N-1:0] ex [5];
        rq = '{4'b1001, 4'b1000, 4'b1001, 4'b1001, 4'b1000};
        lk = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
`ifdef MEM_ARB_LOCK_EN
        ex = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b1000};
`else
        ex = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b1000};
`endif
        do_reset();
        we = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            req = rq[i[2:0]];
            lock = lk[i[2:0]];
            r_addr[0] = AW'(i);
            @(negedge clk);
            checks++;
            if (gnt !== ex[i[2:0]]) begin errors++; $display("FAIL lock_gnt[%0d]: got %b expected %b", i, gnt, ex[i[2:0]]); end
        end
        tick();
        req = '0;
        lock = '0;
    endtask

    task automatic test_random();
        bit [N-1:0] pend;
        logic [PW-1:0] ks;
        logic [N-1:0] eg;
        pend = '0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                ks = k[PW-1:0];
                if (m_last == k) pend[ks] = 1'b0;
                if (!pend[ks] && $urandom_range(0, 2) != 0) begin
                    pend[ks] = 1'b1;
                    we[ks] = 1'($urandom);
                    lock[ks] = ($urandom_range(0, 3) == 0);
                    r_addr[ks] = AW'($urandom_range(0, 7));
                    r_wdata[ks] = $urandom;
                end
            end
            req = pend;
            @(negedge clk);
            eg = model_gnt();
            checks++;
            if (gnt !== eg || $countones(gnt) > 1) begin errors++; $display("FAIL rand_gnt[%0d]: got %b expected %b", c, gnt, eg); end
            checks++;
            if (m_w_en !== e_wen || m_r_en !== e_ren) begin
                errors++; $display("FAIL rand_en[%0d]: got w %b r %b expected w %b r %b", c, m_w_en, m_r_en, e_wen, e_ren);
            end
            if (e_wen || e_ren) begin
                checks++;
                if (m_adrs !== e_adrs || (e_wen && m_wdata !== e_wdata)) begin
                    errors++; $display("FAIL rand_cmd[%0d]: got %h/%h expected %h/%h", c, m_adrs, m_wdata, e_adrs, e_wdata);
                end
            end
            checks++;
            if (rvalid !== exp_rv()) begin errors++; $display("FAIL rand_rvalid[%0d]: got %b expected %b", c, rvalid, exp_rv()); end
            if (exp_rv() != '0) begin
                checks++;
                if (rdata !== exp_rd()) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", c, rdata, exp_rd()); end
            end
        end
        tick();
        req = '0;
        lock = '0;
    endtask

    task automatic test_reset_inflight();
        do_reset();
        tick();
        req = 4'b0001;
        we = 4'b0000;
        r_addr[0] = 11'h033;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL infl_gnt: got %b expected 0001", gnt); end
        tick();
        req = '0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (m_r_en !== 1'b1 || gnt !== 4'b0000) begin errors++; $display("FAIL infl_cmd: got r_en %b gnt %b expected 1 0000", m_r_en, gnt); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid !== 4'b0000) begin errors++; $display("FAIL infl_rvalid: got %b expected 0000 (m_r_valid %b)", rvalid, m_r_valid); end
        checks++;
        if ({m_w_en, m_r_en} !== 2'b00 || m_adrs !== '0 || m_wdata !== '0 || dut.rr_ptr !== 2'd0) begin
            errors++; $display("FAIL infl_state: got en %b%b adrs %h wdata %h ptr %0d expected all 0", m_w_en, m_r_en, m_adrs, m_wdata, dut.rr_ptr);
        end
    endtask

    task automatic test_idle();
        do_reset();
        tick();
        req = 4'b0100;
        we = 4'b0100;
        r_addr[2] = 11'h010;
        r_wdata[2] = 32'h0BAD_F00D;
        for (int i = 0; i < 10; i++) begin
            tick();
            req = '0;
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0000 || m_w_en !== e_wen || m_r_en !== 1'b0) begin
                errors++; $display("FAIL idle[%0d]: got gnt %b w %b r %b expected 0000 %b 0", i, gnt, m_w_en, m_r_en, e_wen);
            end
        end
        checks++;
        if (dut.rr_ptr !== 2'd3) begin errors++; $display("FAIL idle_ptr: got %0d expected 3", dut.rr_ptr); end
        tick();
        req = 4'b1111;
        we = '0;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b1000) begin errors++; $display("FAIL idle_resume: got %b expected 1000", gnt); end
        tick();
        req = '0;
    endtask

    task automatic test_spurious();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            spur = 1'b1;
            @(negedge clk);
            checks++;
            if (rvalid !== 4'b0000) begin errors++; $display("FAIL spurious[%0d]: got %b expected 0000", i, rvalid); end
        end
        tick();
        spur = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mem[i[AW-1:0]] = DW'(i) ^ 32'h5A00_0000;
            ref_mem[i[AW-1:0]] = DW'(i) ^ 32'h5A00_0000;
        end
        for (int k = 0; k < N; k++) begin
            r_addr[k[PW-1:0]] = '0;
            r_wdata[k[PW-1:0]] = '0;
        end
        test_reset();
        test_rr_sequence();
        test_write_read();
        test_lock();
        test_random();
        test_reset_inflight();
        test_idle();
        test_spurious();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
